// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: word-addressed fetch requests in, instruction words out
// in order after a fixed read latency, through a credit-checked output queue.
module instr_mem_responder #(
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 32,
    parameter int DATA_W    = 32,
    parameter int LATENCY   = 2,
    parameter int OUT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              busy
);

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [ADDR_W:0]    DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(OUT_DEPTH - 1);
    localparam logic [SUM_W-1:0]   CREDITS  = SUM_W'(OUT_DEPTH);

    function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_pop;
    logic              w_req_in_range;
    logic              w_ld_in_range;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_push;
    logic [DATA_W-1:0] w_push_data;
    logic              w_push_err;
    logic [SUM_W-1:0]  w_used;

    logic [CNT_W-1:0]  r_inflight;
    logic [CNT_W-1:0]  r_q_count;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [DATA_W-1:0] r_q_data [OUT_DEPTH];
    logic [OUT_DEPTH-1:0] r_q_err;

    assign w_req_in_range = {1'b0, req_addr} < DEPTH_C;
    assign w_ld_in_range  = {1'b0, ld_addr} < DEPTH_C;
    assign w_rd_data      = w_req_in_range ? r_mem[req_addr] : '0;

    assign resp_valid = (r_q_count != '0);
    assign w_pop      = resp_valid && resp_ready;
    assign resp_data  = resp_valid ? r_q_data[r_rd_ptr] : '0;
    assign resp_err   = resp_valid && r_q_err[r_rd_ptr];

    // A same-cycle pop returns its credit immediately, so a full queue still accepts.
    assign w_used    = SUM_W'(r_inflight) + SUM_W'(r_q_count) - SUM_W'(w_pop);
    assign req_ready = reset && !ld_en && (w_used < CREDITS);
    assign w_accept  = req_valid && req_ready;
    assign busy      = (r_inflight != '0) || (r_q_count != '0);

    always_ff @(posedge clk) begin
        if (ld_en && w_ld_in_range) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

    // Stage p0: array read at the accept edge; later stages only delay the word
    generate
        if (LATENCY == 1) begin : g_lat1
            assign w_push      = w_accept;
            assign w_push_data = w_rd_data;
            assign w_push_err  = !w_req_in_range;
        end else begin : g_pipe
            logic [LATENCY-2:0] r_vld_p;
            logic [LATENCY-2:0] r_err_p;
            logic [DATA_W-1:0]  r_data_p [LATENCY-1];

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_vld_p <= '0;
                end else begin
                    r_vld_p[0] <= w_accept;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        r_vld_p[i] <= r_vld_p[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                r_data_p[0] <= w_rd_data;
                r_err_p[0]  <= !w_req_in_range;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    r_data_p[i] <= r_data_p[i-1];
                    r_err_p[i]  <= r_err_p[i-1];
                end
            end

            assign w_push      = r_vld_p[LATENCY-2];
            assign w_push_data = r_data_p[LATENCY-2];
            assign w_push_err  = r_err_p[LATENCY-2];
        end
    endgenerate

    // Queue stage: credit check guarantees a free slot for every push
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_inflight <= '0;
            r_q_count  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            case ({w_accept, w_push})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
            case ({w_push, w_pop})
                2'b10:   r_q_count <= r_q_count + 1'b1;
                2'b01:   r_q_count <= r_q_count - 1'b1;
                default: r_q_count <= r_q_count;
            endcase
            if (w_push) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_data[r_wr_ptr] <= w_push_data;
            r_q_err[r_wr_ptr]  <= w_push_err;
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder (DEPTH=20, LATENCY=2, OUT_DEPTH=4).
module tb_instr_mem_responder;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_mem_responder #(
        .ADDR_W(ADDR_W), .DEPTH(20), .DATA_W(DATA_W), .LATENCY(2), .OUT_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .busy(busy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        cyc();
        ld_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b1; req_addr = '0; resp_ready = 1'b1;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_ready: got %b want 0", req_ready);
        end
        req_valid = 1'b0;
        cyc();
        n_cmp++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_data !== 32'h0 || resp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: valid=%b busy=%b data=%h err=%b want 0/0/0/0",
                     resp_valid, busy, resp_data, resp_err);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL ready_after_reset: got %b want 1", req_ready);
        end
    endtask

    task automatic load_program();
        for (int i = 0; i < 4; i++) do_load(ADDR_W'(i), 32'h11111111 * (i + 1));
        do_load(5'd5, 32'h55555555);
        do_load(5'd19, 32'h19191919);
        do_load(5'd20, 32'hBADBADBA);
    endtask

    task automatic test_in_order();
        logic [DATA_W-1:0] exp_w;
        resp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_valid = (k < 4);
            req_addr  = ADDR_W'(k);
            #1;
            if (k < 4) begin
                n_cmp++;
                if (req_ready !== 1'b1) begin
                    n_bad++; $display("FAIL inorder_ready k=%0d: got %b want 1", k, req_ready);
                end
            end
            cyc();
            n_cmp++;
            if (k >= 1 && k <= 4) begin
                exp_w = 32'h11111111 * k;
                if (resp_valid !== 1'b1 || resp_data !== exp_w || resp_err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL inorder_resp k=%0d: valid=%b data=%h err=%b want 1/%h/0",
                             k, resp_valid, resp_data, resp_err, exp_w);
                end
            end else if (resp_valid !== 1'b0) begin
                n_bad++; $display("FAIL inorder_idle k=%0d: valid=%b want 0", k, resp_valid);
            end
        end
        req_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL inorder_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_backpressure();
        int n_acc;
        logic [DATA_W-1:0] exp_seq [4];
        n_acc = 0;
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_addr = ADDR_W'(n_acc);
            #1;
            if (req_ready) n_acc++;
            cyc();
        end
        n_cmp++;
        if (n_acc !== 4) begin
            n_bad++; $display("FAIL bp_accepted: got %0d want 4", n_acc);
        end
        n_cmp++;
        if (req_ready !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL bp_full: ready=%b busy=%b want 0/1", req_ready, busy);
        end
        resp_ready = 1'b1;
        req_addr   = 5'd0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1 || resp_data !== 32'h11111111) begin
            n_bad++;
            $display("FAIL bp_recover: ready=%b data=%h want 1/11111111", req_ready, resp_data);
        end
        cyc();
        req_valid = 1'b0;
        exp_seq = '{32'h22222222, 32'h33333333, 32'h44444444, 32'h11111111};
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (resp_valid !== 1'b1 || resp_data !== exp_seq[k]) begin
                n_bad++;
                $display("FAIL bp_drain k=%0d: valid=%b data=%h want 1/%h",
                         k, resp_valid, resp_data, exp_seq[k]);
            end
            cyc();
        end
        n_cmp++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            n_bad++; $display("FAIL bp_empty: busy=%b valid=%b want 0/0", busy, resp_valid);
        end
    endtask

    task automatic test_load_inflight();
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 5'd5;
        cyc();
        ld_en = 1'b1; ld_addr = 5'd5; ld_data = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_bad++; $display("FAIL ld_blocks_ready: got %b want 0", req_ready);
        end
        cyc();
        ld_en = 1'b0;
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h55555555) begin
            n_bad++;
            $display("FAIL ld_old_word: valid=%b data=%h want 1/55555555", resp_valid, resp_data);
        end
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL ld_ready_back: got %b want 1", req_ready);
        end
        cyc();
        req_valid = 1'b0;
        n_cmp++;
        if (resp_valid !== 1'b0) begin
            n_bad++; $display("FAIL ld_gap: valid=%b want 0", resp_valid);
        end
        cyc();
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_data !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL ld_new_word: valid=%b data=%h want 1/deadbeef", resp_valid, resp_data);
        end
        cyc();
    endtask

    task automatic test_out_of_range();
        logic [ADDR_W-1:0] addrs [5];
        logic [DATA_W-1:0] exp_d [5];
        logic              exp_e [5];
        addrs = '{5'd1, 5'd25, 5'd20, 5'd2, 5'd19};
        exp_d = '{32'h22222222, 32'h0, 32'h0, 32'h33333333, 32'h19191919};
        exp_e = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        resp_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            req_valid = (k < 5);
            req_addr  = (k < 5) ? addrs[k] : 5'd0;
            cyc();
            if (k >= 1 && k <= 5) begin
                n_cmp++;
                if (resp_valid !== 1'b1 || resp_data !== exp_d[k-1] || resp_err !== exp_e[k-1]) begin
                    n_bad++;
                    $display("FAIL oor_resp k=%0d: valid=%b data=%h err=%b want 1/%h/%b",
                             k, resp_valid, resp_data, resp_err, exp_d[k-1], exp_e[k-1]);
                end
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset_flush();
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_addr = ADDR_W'(k);
            cyc();
        end
        req_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || resp_valid !== 1'b1) begin
            n_bad++; $display("FAIL flush_pre: busy=%b valid=%b want 1/1", busy, resp_valid);
        end
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        n_cmp++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_data !== 32'h0) begin
            n_bad++;
            $display("FAIL flush_post: valid=%b busy=%b data=%h want 0/0/0",
                     resp_valid, busy, resp_data);
        end
        resp_ready = 1'b1;
        cyc();
        cyc();
        n_cmp++;
        if (resp_valid !== 1'b0) begin
            n_bad++; $display("FAIL flush_leak: valid=%b want 0", resp_valid);
        end
        req_valid = 1'b1;
        req_addr  = 5'd2;
        cyc();
        req_valid = 1'b0;
        cyc();
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h33333333) begin
            n_bad++;
            $display("FAIL flush_retained: valid=%b data=%h want 1/33333333", resp_valid, resp_data);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] new_a [10];
        logic [DATA_W-1:0] new_d [10];
        logic [DATA_W-1:0] exp_w;
        new_a = '{5'd5, 5'd19, 5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd19, 5'd0, 5'd1};
        new_d = '{32'hDEADBEEF, 32'h19191919, 32'h11111111, 32'h22222222, 32'h33333333,
                  32'h44444444, 32'hDEADBEEF, 32'h19191919, 32'h11111111, 32'h22222222};
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_addr = ADDR_W'(k % 4);
            cyc();
        end
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_bad++; $display("FAIL b2b_full: ready=%b want 0", req_ready);
        end
        resp_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            req_valid = (k < 10);
            req_addr  = (k < 10) ? new_a[k] : 5'd0;
            exp_w     = (k < 4) ? 32'h11111111 * (k + 1) : new_d[k-4];
            #1;
            n_cmp++;
            if (k < 10 && (req_ready !== 1'b1 || busy !== 1'b1)) begin
                n_bad++;
                $display("FAIL b2b_ready k=%0d: ready=%b busy=%b want 1/1", k, req_ready, busy);
            end
            if (resp_valid !== 1'b1 || resp_data !== exp_w) begin
                n_bad++;
                $display("FAIL b2b_resp k=%0d: valid=%b data=%h want 1/%h",
                         k, resp_valid, resp_data, exp_w);
            end
            cyc();
        end
        n_cmp++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            n_bad++; $display("FAIL b2b_empty: busy=%b valid=%b want 0/0", busy, resp_valid);
        end
    endtask

    initial begin
        test_reset();
        load_program();
        test_in_order();
        test_backpressure();
        test_load_inflight();
        test_out_of_range();
        test_reset_flush();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
